limb_carry_normalizer: RTL and testbench



---
 rtl/limb_carry_normalizer_if.sv | 16 +
 rtl/limb_carry_normalizer.sv | 133 +++++++++++++
 tb/tb_limb_carry_normalizer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/limb_carry_normalizer_if.sv
// Valid/ready stream bundle with a last marker. One instance carries the
// column sums into the normalizer and another carries the limbs out of it.
interface limb_carry_normalizer_if #(
  parameter int DATA_WIDTH = 18
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  // The producer drives valid/data/last. The consumer drives ready.
  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/limb_carry_normalizer.sv
// Carry-propagating normalizer for big-integer column sums.
// Each accepted column sum is added to the running carry. The low LIMB_WIDTH
// bits leave as a limb, and the upper bits become the new carry. After the
// last column, the residual carry is emitted as FLUSH_LIMBS extra limbs, so
// every number leaves in canonical radix-2^LIMB_WIDTH form.
module limb_carry_normalizer #(
  parameter int LIMB_WIDTH  = 18,
  parameter int SUM_WIDTH   = 36,
  parameter int CARRY_WIDTH = SUM_WIDTH + 1 - LIMB_WIDTH,
  parameter int FLUSH_LIMBS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sclr,
  limb_carry_normalizer_if.slave         s,
  limb_carry_normalizer_if.master        m,
  output logic                           busy
);

  localparam logic [0:0] ST_ACC   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int CNT_WIDTH = (FLUSH_LIMBS > 1) ? $clog2(FLUSH_LIMBS) : 1;
  localparam int PAD_WIDTH = FLUSH_LIMBS * LIMB_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FLUSH_LIMBS - 1);

  logic [0:0]             state_q,  state_d;
  logic [CARRY_WIDTH-1:0] carry_q,  carry_d;
  logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
  logic                   mValid_q, mValid_d;
  logic [LIMB_WIDTH-1:0]  mData_q,  mData_d;
  logic                   mLast_q,  mLast_d;
  logic                   mid_q,    mid_d;

  logic                   outFree;
  logic                   sReady;
  logic                   accept;
  logic                   flushLoad;
  logic                   finalTaken;
  logic [SUM_WIDTH:0]     acc;
  logic [PAD_WIDTH-1:0]   carryPadded;
  logic [LIMB_WIDTH-1:0]  flushLimb;

  // Handshake qualifiers, the column adder, and selection of the current flush limb.
  always_comb begin
    outFree     = !mValid_q | m.ready;
    sReady      = (state_q == ST_ACC) & outFree;
    accept      = s.valid & sReady;
    flushLoad   = (state_q == ST_FLUSH) & outFree;
    finalTaken  = mValid_q & mLast_q & m.ready;
    acc         = {1'b0, s.data} + (SUM_WIDTH + 1)'(carry_q);
    carryPadded = PAD_WIDTH'(carry_q);
    flushLimb   = LIMB_WIDTH'(carryPadded >> (int'(cnt_q) * LIMB_WIDTH));
  end

  // Next-state logic. A synchronous clear overrides any handshake in the same cycle.
  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    mValid_d = mValid_q;
    mData_d  = mData_q;
    mLast_d  = mLast_q;
    mid_d    = mid_q;

    if (accept) begin
      mData_d  = acc[LIMB_WIDTH-1:0];
      mLast_d  = 1'b0;
      mValid_d = 1'b1;
      carry_d  = CARRY_WIDTH'(acc >> LIMB_WIDTH);
      if (s.last) begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    end else if (flushLoad) begin
      mData_d  = flushLimb;
      mValid_d = 1'b1;
      mLast_d  = (cnt_q == CNT_LAST);
      if (cnt_q == CNT_LAST) begin
        carry_d = '0;
        cnt_d   = '0;
        state_d = ST_ACC;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (m.ready) begin
      mValid_d = 1'b0;
    end

    if (finalTaken) begin
      mid_d = 1'b0;
    end
    if (accept) begin
      mid_d = 1'b1;
    end

    if (sclr) begin
      state_d  = ST_ACC;
      carry_d  = '0;
      cnt_d    = '0;
      mValid_d = 1'b0;
      mid_d    = 1'b0;
    end
  end

  // State and output register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACC;
      carry_q  <= '0;
      cnt_q    <= '0;
      mValid_q <= 1'b0;
      mData_q  <= '0;
      mLast_q  <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      mValid_q <= mValid_d;
      mData_q  <= mData_d;
      mLast_q  <= mLast_d;
      mid_q    <= mid_d;
    end
  end

  assign s.ready = sReady;
  assign m.valid = mValid_q;
  assign m.data  = mData_q;
  assign m.last  = mLast_q;
  assign busy    = (state_q == ST_FLUSH) | mValid_q | (carry_q != '0) | mid_q;

endmodule

// File: tb/tb_limb_carry_normalizer.sv
// Scoreboard bench for limb_carry_normalizer. Directed column vectors are
// driven in, and the hand-computed limbs are queued. A monitor pops the queue
// and compares on every output handshake.
module tb_limb_carry_normalizer;

  logic clk = 1'b0;
  logic rst_n;
  logic sclr;
  logic busy;
  int   cycleCount = 0;
  int   checks = 0;
  int   errors = 0;
  logic [18:0] expQ [$];

  limb_carry_normalizer_if #(.DATA_WIDTH(36)) sIf ();
  limb_carry_normalizer_if #(.DATA_WIDTH(18)) mIf ();

  limb_carry_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .s     (sIf.slave),
    .m     (mIf.master),
    .busy  (busy)
  );

  // Free-running clock and cycle counter, used to measure input-side bubbles.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic expectLimb(input logic [17:0] data, input logic last);
    expQ.push_back({last, data});
  endtask

  // Presents one column and waits, with a bound, for the edge that accepts it.
  task automatic applyStimulus(input logic [35:0] data, input logic last, output int acceptCycle);
    logic accepted;
    accepted   = 1'b0;
    sIf.valid  = 1'b1;
    sIf.data   = data;
    sIf.last   = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sIf.ready) accepted = 1'b1;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    acceptCycle = cycleCount;
    sIf.valid   = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: column 0x%0h never accepted, expected acceptance", data);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0 && !mIf.valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("queue drained", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: every limb taken by the output handshake is compared to the head of the queue.
  always @(negedge clk) begin
    logic [18:0] exp;
    if (rst_n && !sclr && mIf.valid && mIf.ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected limb: got 0x%0h, expected none", mIf.data);
      end else begin
        exp = expQ.pop_front();
        checkOutput("limb data", 64'(mIf.data), 64'(exp[17:0]));
        checkOutput("limb last", 64'(mIf.last), 64'(exp[18]));
      end
    end
  end

  initial begin
    int c1;
    int c2;
    rst_n     = 1'b0;
    sclr      = 1'b0;
    sIf.valid = 1'b0;
    sIf.data  = '0;
    sIf.last  = 1'b0;
    mIf.ready = 1'b1;

    #1;
    checkOutput("reset m_valid", 64'(mIf.valid), 64'd0);
    checkOutput("reset m_data", 64'(mIf.data), 64'd0);
    checkOutput("reset m_last", 64'(mIf.last), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("post-reset s_ready", 64'(sIf.ready), 64'd1);

    $display("[TB] carry ripple");
    expectLimb(18'h00005, 1'b0);
    expectLimb(18'h00000, 1'b0);
    expectLimb(18'h00001, 1'b0);
    expectLimb(18'h00000, 1'b1);
    applyStimulus(36'h0_0004_0005, 1'b0, c1);
    applyStimulus(36'h0_0003_FFFF, 1'b1, c1);
    checkOutput("s_ready low t", 64'(sIf.ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("s_ready low t+1", 64'(sIf.ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("s_ready high t+2", 64'(sIf.ready), 64'd1);
    waitDrain();

    $display("[TB] max values");
    expectLimb(18'h3FFFF, 1'b0);
    expectLimb(18'h3FFFE, 1'b0);
    expectLimb(18'h3FFFF, 1'b0);
    expectLimb(18'h00000, 1'b0);
    expectLimb(18'h00001, 1'b1);
    applyStimulus(36'hF_FFFF_FFFF, 1'b0, c1);
    applyStimulus(36'hF_FFFF_FFFF, 1'b0, c1);
    applyStimulus(36'hF_FFFF_FFFF, 1'b1, c1);
    waitDrain();

    $display("[TB] backpressure");
    expectLimb(18'h00005, 1'b0);
    expectLimb(18'h00000, 1'b0);
    expectLimb(18'h00001, 1'b0);
    expectLimb(18'h00000, 1'b1);
    applyStimulus(36'h0_0004_0005, 1'b0, c1);
    mIf.ready = 1'b0;
    sIf.valid = 1'b1;
    sIf.data  = 36'h0_0003_FFFF;
    sIf.last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall m_valid", 64'(mIf.valid), 64'd1);
      checkOutput("stall m_data", 64'(mIf.data), 64'h5);
      checkOutput("stall m_last", 64'(mIf.last), 64'd0);
      checkOutput("stall s_ready", 64'(sIf.ready), 64'd0);
    end
    @(posedge clk); #1;
    mIf.ready = 1'b1;
    applyStimulus(36'h0_0003_FFFF, 1'b1, c1);
    waitDrain();

    $display("[TB] abort");
    // 0x7FFFF gives limb 0x3FFFF with carry 1; 0x40000 + 1 keeps carry 1 pending.
    expectLimb(18'h3FFFF, 1'b0);
    applyStimulus(36'h0_0007_FFFF, 1'b0, c1);
    applyStimulus(36'h0_0004_0000, 1'b0, c1);
    sclr      = 1'b1;
    mIf.ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort m_valid", 64'(mIf.valid), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort s_ready", 64'(sIf.ready), 64'd1);
    sclr      = 1'b0;
    mIf.ready = 1'b1;
    expectLimb(18'h00007, 1'b0);
    expectLimb(18'h00000, 1'b0);
    expectLimb(18'h00000, 1'b1);
    applyStimulus(36'h0_0000_0007, 1'b1, c1);
    waitDrain();

    $display("[TB] back-to-back single-column numbers");
    // 0x1_0000_0003: low limb 3, carry 0x1_0000_0000 >> 18 = 0x4000.
    expectLimb(18'h00003, 1'b0);
    expectLimb(18'h04000, 1'b0);
    expectLimb(18'h00000, 1'b1);
    expectLimb(18'h00002, 1'b0);
    expectLimb(18'h00000, 1'b0);
    expectLimb(18'h00000, 1'b1);
    applyStimulus(36'h1_0000_0003, 1'b1, c1);
    applyStimulus(36'h0_0000_0002, 1'b1, c2);
    checkOutput("input bubble", 64'(c2 - c1), 64'd3);
    waitDrain();

    $display("[TB] mid-stream reset");
    applyStimulus(36'hF_FFFF_FFFF, 1'b0, c1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset m_valid", 64'(mIf.valid), 64'd0);
    checkOutput("async reset busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("release s_ready", 64'(sIf.ready), 64'd1);
    checkOutput("release busy", 64'(busy), 64'd0);
    checkOutput("release m_valid", 64'(mIf.valid), 64'd0);
    expectLimb(18'h00007, 1'b0);
    expectLimb(18'h00000, 1'b0);
    expectLimb(18'h00000, 1'b1);
    applyStimulus(36'h0_0000_0007, 1'b1, c1);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
